// File: rtl/arb4_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
package arb4_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int          NUM_REQ  = 4;
    localparam logic [3:0]  GNT_NONE = 4'b1111;

    // Active-low one-hot grant for a requester index.
    function automatic logic [3:0] idx_to_gnt_l(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/arb4_rr_ctrl_if.sv
// Request/grant bus between the requesting units and the arbiter.
interface arb4_rr_ctrl_if;
    import arb4_pkg::*;

    logic               EN_L;
    logic [NUM_REQ-1:0] REQ;
    logic [NUM_REQ-1:0] GNT_L;
    logic [1:0]         GSEL;
    logic               BUSY;
    logic               TIMEOUT;

    // Requester side: drives enable and requests, observes grants.
    modport master (
        output EN_L, REQ,
        input  GNT_L, GSEL, BUSY, TIMEOUT
    );

    // Arbiter side.
    modport slave (
        input  EN_L, REQ,
        output GNT_L, GSEL, BUSY, TIMEOUT
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request after the pointer wins.
module rr_pick4
    import arb4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic               valid_o,
    output logic [1:0]         win_o
);

    // Walk the search order from lowest to highest priority so the last hit
    // (ptr+1) overrides the others; ptr itself is searched last.
    always_comb begin
        logic [1:0] idx;
        valid_o = |req_i;
        win_o   = ptr_i;
        idx     = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr_i + 2'(k);
            if (req_i[idx]) begin
                win_o = idx;
            end
        end
    end

endmodule

// File: rtl/arb4_rr_ctrl.sv
// Four-requester round-robin arbiter with hold-time cap, active-low grants.
module arb4_rr_ctrl
    import arb4_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    arb4_rr_ctrl_if.slave       bus
);

    localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [1:0] ptr_q;
    logic [3:0] gnt_l_q;
    logic [1:0] gsel_q;
    logic       busy_q;
    logic       timeout_q;

    logic       pick_valid;
    logic [1:0] pick_win;

    rr_pick4 u_pick (
        .req_i   (bus.REQ),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .win_o   (pick_win)
    );

    // Arbitration FSM with registered grant outputs; the owner is always ptr_q
    // while in GRANT.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            ptr_q     <= 2'b11;
            gnt_l_q   <= GNT_NONE;
            gsel_q    <= 2'b00;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE, RELEASE: begin
                    if (!bus.EN_L && pick_valid) begin
                        state_q <= GRANT;
                        gnt_l_q <= idx_to_gnt_l(pick_win);
                        gsel_q  <= pick_win;
                        busy_q  <= 1'b1;
                        ptr_q   <= pick_win;
                        cnt_q   <= 8'd1;
                    end else begin
                        state_q <= IDLE;
                        gnt_l_q <= GNT_NONE;
                        busy_q  <= 1'b0;
                        cnt_q   <= 8'd0;
                    end
                end
                GRANT: begin
                    if (bus.EN_L) begin
                        // Disable drops straight to IDLE, skipping the gap state.
                        state_q <= IDLE;
                        gnt_l_q <= GNT_NONE;
                        busy_q  <= 1'b0;
                        cnt_q   <= 8'd0;
                    end else if (!bus.REQ[ptr_q]) begin
                        state_q <= RELEASE;
                        gnt_l_q <= GNT_NONE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == HOLD_MAX_C) begin
                        state_q   <= RELEASE;
                        gnt_l_q   <= GNT_NONE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_l_q <= GNT_NONE;
                    busy_q  <= 1'b0;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

    assign bus.GNT_L   = gnt_l_q;
    assign bus.GSEL    = gsel_q;
    assign bus.BUSY    = busy_q;
    assign bus.TIMEOUT = timeout_q;

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Self-checking bench for arb4_rr_ctrl: two instances (HOLD_MAX=2 and 16)
// share one stimulus stream and are compared each cycle against a model.
module tb_arb4_rr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_l = 1'b1;
    logic [3:0] req = 4'b0000;
    bit         chk_on = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    arb4_rr_ctrl_if bus_a ();
    arb4_rr_ctrl_if bus_b ();

    assign bus_a.EN_L = en_l;
    assign bus_a.REQ  = req;
    assign bus_b.EN_L = en_l;
    assign bus_b.REQ  = req;

    arb4_rr_ctrl #(.HOLD_MAX(2))  dut_a (.CLK(clk), .RST_N(rst_n), .bus(bus_a));
    arb4_rr_ctrl #(.HOLD_MAX(16)) dut_b (.CLK(clk), .RST_N(rst_n), .bus(bus_b));

    // Behavioural model: who owns the resource, for how long, and who owned it last.
    typedef struct {
        int owner;   // -1 when nobody holds a grant
        int held;    // cycles the current owner has held the grant
        int last;    // last owner, shown on GSEL
        int ptr;     // search starts after this requester
        bit to;      // timeout pulse
    } mdl_t;

    mdl_t m_a = '{owner: -1, held: 0, last: 0, ptr: 3, to: 1'b0};
    mdl_t m_b = '{owner: -1, held: 0, last: 0, ptr: 3, to: 1'b0};

    function automatic mdl_t mstep(mdl_t m, int hm, logic rs, logic en, logic [3:0] r);
        mdl_t n = m;
        int   w;
        bit   found;
        n.to = 1'b0;
        if (!rs) begin
            n.owner = -1; n.held = 0; n.last = 0; n.ptr = 3;
        end else if (m.owner >= 0) begin
            if (en) n.owner = -1;
            else if (!r[m.owner]) n.owner = -1;
            else if (m.held == hm) begin n.owner = -1; n.to = 1'b1; end
            else n.held = m.held + 1;
        end else if (!en && r != 4'b0000) begin
            found = 1'b0;
            w = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && r[(m.ptr + k) % 4]) begin
                    w = (m.ptr + k) % 4;
                    found = 1'b1;
                end
            end
            n.owner = w; n.last = w; n.ptr = w; n.held = 1;
        end
        return n;
    endfunction

    function automatic logic [3:0] exp_gnt(mdl_t m);
        return (m.owner < 0) ? 4'b1111 : ~(4'b0001 << m.owner);
    endfunction

    always @(posedge clk) begin
        m_a <= mstep(m_a, 2, rst_n, en_l, req);
        m_b <= mstep(m_b, 16, rst_n, en_l, req);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("A.GNT_L",   32'(bus_a.GNT_L),   32'(exp_gnt(m_a)));
            chk("A.GSEL",    32'(bus_a.GSEL),    32'(m_a.last));
            chk("A.BUSY",    32'(bus_a.BUSY),    32'(m_a.owner >= 0));
            chk("A.TIMEOUT", 32'(bus_a.TIMEOUT), 32'(m_a.to));
            chk("B.GNT_L",   32'(bus_b.GNT_L),   32'(exp_gnt(m_b)));
            chk("B.GSEL",    32'(bus_b.GSEL),    32'(m_b.last));
            chk("B.BUSY",    32'(bus_b.BUSY),    32'(m_b.owner >= 0));
            chk("B.TIMEOUT", 32'(bus_b.TIMEOUT), 32'(m_b.to));
        end
    end

    task automatic drive(input logic en, input logic [3:0] r, input logic rs);
        en_l  = en;
        req   = r;
        rst_n = rs;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [3:0] rot_gnt [13] = '{4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1111,
                                 4'b1011, 4'b1011, 4'b1111, 4'b0111, 4'b0111, 4'b1111,
                                 4'b1110};
    logic       rot_to  [13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [3:0] rq;
        logic       e;
        @(negedge clk);

        // Reset with everything requesting.
        drive(1'b0, 4'b1111, 1'b0);
        chk_on = 1'b1;
        drive(1'b0, 4'b1111, 1'b0);
        chk("rst.GNT_L", 32'(bus_a.GNT_L), 32'h0000000f);
        chk("rst.BUSY",  32'(bus_a.BUSY),  32'h0);
        chk("rst.GSEL",  32'(bus_b.GSEL),  32'h0);

        // Rotation on the HOLD_MAX=2 instance, starting at reset release.
        for (int i = 0; i < 13; i++) begin
            drive(1'b0, 4'b1111, 1'b1);
            chk($sformatf("rot.GNT_L[%0d]", i),   32'(bus_a.GNT_L),   32'(rot_gnt[i]));
            chk($sformatf("rot.TIMEOUT[%0d]", i), 32'(bus_a.TIMEOUT), 32'(rot_to[i]));
        end

        // Voluntary release by requester 2.
        drive(1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0100, 1'b1);
            chk("vol.GNT_L", 32'(bus_b.GNT_L), 32'h0000000b);
        end
        drive(1'b0, 4'b0000, 1'b1);
        chk("vol.end.GNT_L",   32'(bus_b.GNT_L),   32'h0000000f);
        chk("vol.end.TIMEOUT", 32'(bus_b.TIMEOUT), 32'h0);
        chk("vol.end.GSEL",    32'(bus_b.GSEL),    32'h2);

        // Sole requester 3 against HOLD_MAX=16.
        drive(1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'b1000, 1'b1);
            chk($sformatf("sole.GNT_L[%0d]", i), 32'(bus_b.GNT_L), 32'h00000007);
        end
        drive(1'b0, 4'b1000, 1'b1);
        chk("sole.gap.GNT_L",   32'(bus_b.GNT_L),   32'h0000000f);
        chk("sole.gap.TIMEOUT", 32'(bus_b.TIMEOUT), 32'h1);
        drive(1'b0, 4'b1000, 1'b1);
        chk("sole.regrant",     32'(bus_b.GNT_L),   32'h00000007);

        // Enable gating.
        drive(1'b0, 4'b0000, 1'b0);
        drive(1'b1, 4'b0010, 1'b1);
        drive(1'b1, 4'b0010, 1'b1);
        chk("en.off.GNT_L", 32'(bus_b.GNT_L), 32'h0000000f);
        drive(1'b0, 4'b0010, 1'b1);
        chk("en.on.GNT_L",  32'(bus_b.GNT_L), 32'h0000000d);
        drive(1'b0, 4'b0010, 1'b1);
        drive(1'b1, 4'b0010, 1'b1);
        chk("en.drop.GNT_L",   32'(bus_b.GNT_L),   32'h0000000f);
        chk("en.drop.TIMEOUT", 32'(bus_b.TIMEOUT), 32'h0);
        chk("en.drop.BUSY",    32'(bus_b.BUSY),    32'h0);

        // Reset in the middle of a grant.
        drive(1'b0, 4'b0000, 1'b0);
        drive(1'b0, 4'b0100, 1'b1);
        chk("mid.GNT_L", 32'(bus_b.GNT_L), 32'h0000000b);
        drive(1'b0, 4'b0100, 1'b0);
        chk("mid.rst.GNT_L", 32'(bus_b.GNT_L), 32'h0000000f);
        chk("mid.rst.GSEL",  32'(bus_b.GSEL),  32'h0);
        chk("mid.rst.BUSY",  32'(bus_b.BUSY),  32'h0);
        drive(1'b0, 4'b0101, 1'b1);
        chk("mid.after.GNT_L", 32'(bus_b.GNT_L), 32'h0000000e);

        // Randomized traffic; requests tend to persist so long holds occur.
        rq = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) rq = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 19) == 0);
            drive(e, rq, ($urandom_range(0, 299) != 0));
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
